// File: rtl/multi_mem_pkg.sv
// Shared types and defaults for the multicycle memory responder.
// State encoding, default geometry and the word-alignment mask.
package multi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        READ_WAIT = 3'd2,
        WRITE     = 3'd3,
        RESP      = 3'd4
    } state_t;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_LAT = 2;

    localparam logic [1:0] MISALIGN_MASK = 2'b11;

endpackage

// File: rtl/multi_mem_responder_if.sv
// Core request/response bus plus the BRAM port of the memory responder.
// master = core and memory side, slave = the responder itself.
interface multi_mem_responder_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, bram_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  bram_en, bram_we, bram_addr, bram_din
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, bram_dout,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/multi_mem_lat_counter.sv
// Loadable down-counter timing the BRAM read latency.
// zero_o reports that the count is (or is about to become) zero at the next edge.
module multi_mem_lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_d == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/multi_mem_responder.sv
// Single-outstanding memory responder between the multicycle core and a BRAM.
// Define MEM_RANGE_CHECK_EN to reject addresses above the BRAM size.
module multi_mem_responder
    import multi_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic clk,
    input  logic rst,
    multi_mem_responder_if.slave bus
);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic              misaligned, out_of_range, addr_err;

    assign misaligned = (bus.req_addr[1:0] & MISALIGN_MASK) != 2'b00;
`ifdef MEM_RANGE_CHECK_EN
    assign out_of_range = (bus.req_addr >> (ADDR_W + 2)) != 32'd0;
`else
    assign out_of_range = 1'b0;
`endif
    assign addr_err = misaligned || out_of_range;

    multi_mem_lat_counter #(.W(CNT_W)) u_lat (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(RD_LAT - 1)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr[ADDR_W+1:2];
                    wdata_d = bus.req_wdata;
                    err_d   = addr_err;
                    if (addr_err)        state_d = RESP;
                    else if (bus.req_we) state_d = WRITE;
                    else                 state_d = READ;
                end
            end
            READ: begin
                cnt_load = 1'b1;
                // A single-cycle BRAM has its data ready as the enable cycle ends.
                if (RD_LAT == 1) begin
                    rdata_d = bus.bram_dout;
                    state_d = RESP;
                end else begin
                    state_d = READ_WAIT;
                end
            end
            READ_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    rdata_d = bus.bram_dout;
                    state_d = RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = (state_q == RESP) && err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.bram_en    = (state_q == READ) || (state_q == WRITE);
    assign bus.bram_we    = (state_q == WRITE);
    assign bus.bram_addr  = addr_q;
    assign bus.bram_din   = wdata_q;
endmodule

// File: tb/tb_multi_mem_responder.sv
// Directed bench for multi_mem_responder with a behavioural fixed-latency BRAM.
// Build with MEM_RANGE_CHECK_EN defined to exercise the range-check variant.
module tb_multi_mem_responder;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multi_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    multi_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // BRAM model: data appears RD_LAT-1 cycles after the enable cycle.
    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] pipe [0:3];

    always @(posedge clk) begin
        if (bus.bram_en && bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
        if (bus.bram_en && !bus.bram_we) pipe[0] <= mem[bus.bram_addr];
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    always_comb begin
        bus.bram_dout = (RD_LAT == 1) ? mem[bus.bram_addr] : pipe[(RD_LAT >= 2) ? RD_LAT - 2 : 0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic err, output logic [31:0] rdata,
                          output logic en_seen, output logic we_seen,
                          output logic [ADDR_W-1:0] a_seen, output logic [31:0] din_seen);
        @(negedge clk);
        check("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0; err = 1'b0; rdata = '0;
        en_seen = 1'b0; we_seen = 1'b0; a_seen = '0; din_seen = '0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.bram_en) begin
                en_seen  = 1'b1;
                we_seen  = bus.bram_we;
                a_seen   = bus.bram_addr;
                din_seen = bus.bram_din;
            end
            if (bus.resp_valid) begin
                err   = bus.resp_err;
                rdata = bus.resp_rdata;
                break;
            end
        end
        if (!bus.resp_valid) check("resp_timeout", {31'b0, bus.resp_valid}, 32'd1);
    endtask

    typedef struct {
        logic              we;
        logic [31:0]       addr;
        logic [31:0]       wdata;
        logic              exp_err;
        logic [31:0]       exp_rdata;
        logic [ADDR_W-1:0] exp_baddr;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin
        int lat, exp_lat, nresp, accepts, extra;
        int acc_t [3];
        int resp_t [3];
        logic err, en_seen, we_seen;
        logic [31:0] rdata, din_seen;
        logic [ADDR_W-1:0] a_seen;

        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 14'd4};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 14'd4};
        vecs[2] = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF, 14'd0};
`ifdef MEM_RANGE_CHECK_EN
        vecs[3] = '{1'b0, 32'h0001_0000, 32'h0,         1'b1, 32'hDEAD_BEEF, 14'd0};
`else
        vecs[3] = '{1'b0, 32'h0001_0000, 32'h0,         1'b0, 32'hA000_0000, 14'd0};
`endif
        vecs[4] = '{1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'hA000_0002, 14'd2};
        vecs[5] = '{1'b1, 32'h0000_0002, 32'h5555_5555, 1'b1, 32'hA000_0002, 14'd0};
        vecs[6] = '{1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'hA000_0001, 14'd1};
        vecs[7] = '{1'b1, 32'h0000_FFFC, 32'h1234_5678, 1'b0, 32'hA000_0001, 14'h3FFF};
        vecs[8] = '{1'b0, 32'h0000_FFFC, 32'h0,         1'b0, 32'h1234_5678, 14'h3FFF};

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        repeat (2) @(negedge clk);
        check("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);
        check("rst_resp_rdata", bus.resp_rdata,          32'd0);
        check("rst_bram_en",    {31'b0, bus.bram_en},    32'd0);
        check("rst_bram_we",    {31'b0, bus.bram_we},    32'd0);
        check("rst_bram_addr",  {18'b0, bus.bram_addr},  32'd0);
        check("rst_bram_din",   bus.bram_din,            32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, err, rdata, en_seen, we_seen, a_seen, din_seen);
            exp_lat = vecs[i].exp_err ? 1 : (vecs[i].we ? 2 : RD_LAT + 1);
            $display("txn %0d we=%0b addr=%h err=%0b rdata=%h lat=%0d", i, vecs[i].we, vecs[i].addr, err, rdata, lat);
            check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_lat", i), lat, exp_lat);
            check($sformatf("v%0d_bram_en", i), {31'b0, en_seen}, {31'b0, !vecs[i].exp_err});
            if (!vecs[i].exp_err) begin
                check($sformatf("v%0d_bram_addr", i), {18'b0, a_seen}, {18'b0, vecs[i].exp_baddr});
                check($sformatf("v%0d_bram_we", i), {31'b0, we_seen}, {31'b0, vecs[i].we});
                if (vecs[i].we) check($sformatf("v%0d_bram_din", i), din_seen, vecs[i].wdata);
            end
        end

        // req_valid held high across three reads
        @(negedge clk);
        bus.req_we = 1'b0;
        bus.req_addr = 32'h10;
        bus.req_valid = 1'b1;
        nresp = 0; accepts = 0;
        for (int c = 0; c < 40 && nresp < 3; c++) begin
            if (bus.resp_valid) begin
                resp_t[nresp] = c;
                $display("b2b resp %0d cycle=%0d rdata=%h err=%0b", nresp, c, bus.resp_rdata, bus.resp_err);
                check($sformatf("b2b_rdata%0d", nresp), bus.resp_rdata, 32'hDEAD_BEEF);
                nresp++;
            end
            if (bus.req_valid && bus.req_ready && accepts < 3) begin
                acc_t[accepts] = c;
                accepts++;
                if (accepts == 3) begin
                    @(posedge clk);
                    #1 bus.req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.resp_valid) extra++;
        end
        check("b2b_nresp", nresp, 3);
        check("b2b_accepts", accepts, 3);
        check("b2b_extra_resp", extra, 0);
        if (nresp == 3 && accepts == 3) begin
            check("b2b_acc_gap", acc_t[1] - acc_t[0], RD_LAT + 2);
            check("b2b_resp_gap1", resp_t[1] - resp_t[0], RD_LAT + 2);
            check("b2b_resp_gap2", resp_t[2] - resp_t[1], RD_LAT + 2);
            check("b2b_first_lat", resp_t[0] - acc_t[0], RD_LAT + 1);
        end

        // reset while the read is waiting on the BRAM
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h10;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat ((RD_LAT > 1) ? 2 : 1) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        $display("midrst bram_en=%0b req_ready=%0b resp_valid=%0b", bus.bram_en, bus.req_ready, bus.resp_valid);
        check("midrst_bram_en",    {31'b0, bus.bram_en},    32'd0);
        check("midrst_req_ready",  {31'b0, bus.req_ready},  32'd1);
        check("midrst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("midrst_resp_rdata", bus.resp_rdata,          32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) extra++;
        end
        check("midrst_no_resp", extra, 0);
        do_req(1'b0, 32'h10, 32'h0, lat, err, rdata, en_seen, we_seen, a_seen, din_seen);
        $display("txn postrst we=0 addr=00000010 err=%0b rdata=%h lat=%0d", err, rdata, lat);
        check("postrst_rdata", rdata, 32'hDEAD_BEEF);
        check("postrst_err", {31'b0, err}, 32'd0);
        check("postrst_lat", lat, RD_LAT + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
